// File: rtl/kernel_launch_ctrl_if.sv
// Launch/completion bundle between host, controller and kernel.
// Host side drives start/continue/arguments; controller drives tokens back.
interface kernel_launch_ctrl_if #(
    parameter int NUM_ARGS  = 4,
    parameter int ARG_WIDTH = 32,
    parameter int NUM_ENDS  = 4,
    parameter int RET_WIDTH = 32
);
    logic                          ap_start;
    logic                          ap_ready;
    logic                          ap_done;
    logic                          ap_continue;
    logic [NUM_ARGS*ARG_WIDTH-1:0] args_in;
    logic [NUM_ARGS*ARG_WIDTH-1:0] args_data;
    logic [NUM_ARGS-1:0]           args_valid;
    logic [NUM_ARGS-1:0]           args_ready;
    logic [NUM_ENDS-1:0]           ends_valid;
    logic [NUM_ENDS-1:0]           ends_ready;
    logic [RET_WIDTH-1:0]          ret_in;
    logic [RET_WIDTH-1:0]          ret_out;
    logic [31:0]                   cycle_count;

    modport master (
        output ap_start, ap_continue, args_in,
        output args_ready, ends_valid, ret_in,
        input  ap_ready, ap_done, args_data,
        input  args_valid, ends_ready, ret_out,
        input  cycle_count
    );

    modport slave (
        input  ap_start, ap_continue, args_in,
        input  args_ready, ends_valid, ret_in,
        output ap_ready, ap_done, args_data,
        output args_valid, ends_ready, ret_out,
        output cycle_count
    );
endinterface

// File: rtl/kernel_launch_ctrl.sv
// Kernel launch/completion controller: one-shot argument tokens, unordered end join.
// Define KERNEL_CYCLE_COUNT_EN to build the saturating run-cycle counter.
module kernel_launch_ctrl #(
    parameter int NUM_ARGS  = 4,
    parameter int ARG_WIDTH = 32,
    parameter int NUM_ENDS  = 4,
    parameter int RET_WIDTH = 32,
    parameter bit HOLD_DONE = 1'b0
) (
    input logic                clk,
    input logic                rst,
    kernel_launch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_ARGS-1:0] sent;
    logic [NUM_ENDS-1:0] got;
    logic [NUM_ARGS-1:0] arg_hs;
    logic [NUM_ENDS-1:0] end_hs;
    logic                in_run;
    logic                launch;

    assign in_run = (state == RUN);
    assign launch = (state == IDLE) && bus.ap_start;

    assign bus.ap_ready   = (state == IDLE);
    assign bus.ap_done    = (state == DONE);
    assign bus.args_valid = in_run ? ~sent : '0;
    assign bus.ends_ready = in_run ? ~got  : '0;

    assign arg_hs = bus.args_valid & bus.args_ready;
    assign end_hs = bus.ends_valid & bus.ends_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sent          <= '0;
            got           <= '0;
            bus.args_data <= '0;
            bus.ret_out   <= '0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (bus.ap_start) begin
                        bus.args_data <= bus.args_in;
                        sent          <= '0;
                        got           <= '0;
                        state         <= RUN;
                    end
                end
                (state == RUN): begin
                    sent <= sent | arg_hs;
                    got  <= got | end_hs;
                    if (end_hs[0])
                        bus.ret_out <= bus.ret_in;
                    // Same-cycle handshakes complete the join too.
                    if (&(got | end_hs))
                        state <= DONE;
                end
                (state == DONE): begin
                    if (!HOLD_DONE || bus.ap_continue)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KERNEL_CYCLE_COUNT_EN
    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (launch)
            cnt <= '0;
        else if (in_run && (cnt != 32'hFFFF_FFFF))
            cnt <= cnt + 32'd1;
    end

    assign bus.cycle_count = cnt;
`else
    assign bus.cycle_count = 32'd0;
`endif
endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// Directed vector bench for kernel_launch_ctrl (pulse and held-done builds).
module tb_kernel_launch_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kernel_launch_ctrl_if b0 ();
    kernel_launch_ctrl_if b1 ();

    kernel_launch_ctrl #(.HOLD_DONE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );
    kernel_launch_ctrl #(.HOLD_DONE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        start;
        logic [3:0]  ardy;
        logic [3:0]  ev;
        logic [31:0] ret;
        logic        chk;
        logic        rdy;
        logic        done;
        logic [3:0]  av;
        logic [3:0]  er;
        logic [31:0] ro;
    } vec_t;

    vec_t tbl[18];
    logic [31:0] exp_cc8;
    logic [127:0] arg_exp;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
`ifdef KERNEL_CYCLE_COUNT_EN
        exp_cc8 = 32'd8;
`else
        exp_cc8 = 32'd0;
`endif
        arg_exp = {32'hD, 32'hC, 32'hB, 32'hA};
        //         rst st ardy ev  ret    chk rdy dn av  er  ro
        tbl[0]  = '{1, 0, 4'h0, 4'h0, 32'h0,  0, 0, 0, 4'h0, 4'h0, 32'h0};
        tbl[1]  = '{0, 1, 4'hF, 4'h0, 32'h0,  1, 1, 0, 4'h0, 4'h0, 32'h0};
        tbl[2]  = '{0, 0, 4'hF, 4'h0, 32'h0,  1, 0, 0, 4'hF, 4'hF, 32'h0};
        tbl[3]  = '{0, 1, 4'hF, 4'h4, 32'h0,  1, 0, 0, 4'h0, 4'hF, 32'h0};
        tbl[4]  = '{0, 0, 4'hF, 4'h1, 32'h55, 1, 0, 0, 4'h0, 4'hB, 32'h0};
        tbl[5]  = '{0, 0, 4'hF, 4'h8, 32'h0,  1, 0, 0, 4'h0, 4'hA, 32'h55};
        tbl[6]  = '{0, 0, 4'hF, 4'h2, 32'h0,  1, 0, 0, 4'h0, 4'h2, 32'h55};
        tbl[7]  = '{0, 0, 4'h0, 4'h0, 32'h0,  1, 0, 1, 4'h0, 4'h0, 32'h55};
        tbl[8]  = '{0, 1, 4'h0, 4'h0, 32'h0,  1, 1, 0, 4'h0, 4'h0, 32'h55};
        tbl[9]  = '{0, 0, 4'h0, 4'hF, 32'h77, 1, 0, 0, 4'hF, 4'hF, 32'h55};
        tbl[10] = '{0, 1, 4'h0, 4'h0, 32'h0,  1, 0, 1, 4'h0, 4'h0, 32'h77};
        tbl[11] = '{0, 1, 4'h0, 4'h0, 32'h0,  1, 1, 0, 4'h0, 4'h0, 32'h77};
        tbl[12] = '{1, 0, 4'h0, 4'h0, 32'h0,  1, 0, 0, 4'hF, 4'hF, 32'h77};
        tbl[13] = '{0, 1, 4'h3, 4'h0, 32'h0,  1, 1, 0, 4'h0, 4'h0, 32'h0};
        tbl[14] = '{0, 0, 4'h3, 4'h1, 32'h99, 1, 0, 0, 4'hF, 4'hF, 32'h0};
        tbl[15] = '{0, 0, 4'hF, 4'hE, 32'h0,  1, 0, 0, 4'hC, 4'hE, 32'h99};
        tbl[16] = '{0, 0, 4'h0, 4'h0, 32'h0,  1, 0, 1, 4'h0, 4'h0, 32'h99};
        tbl[17] = '{0, 0, 4'h0, 4'h0, 32'h0,  1, 1, 0, 4'h0, 4'h0, 32'h99};

        rst = 1'b1;
        b0.ap_start = 0; b0.ap_continue = 0; b0.args_in = arg_exp;
        b0.args_ready = 0; b0.ends_valid = 0; b0.ret_in = 0;
        b1.ap_start = 0; b1.ap_continue = 0; b1.args_in = '0;
        b1.args_ready = 0; b1.ends_valid = 0; b1.ret_in = 0;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            rst           = tbl[i].rst;
            b0.ap_start   = tbl[i].start;
            b0.args_ready = tbl[i].ardy;
            b0.ends_valid = tbl[i].ev;
            b0.ret_in     = tbl[i].ret;
            #1;
            if (tbl[i].chk) begin
                chk($sformatf("v%0d ap_ready", i), b0.ap_ready, tbl[i].rdy);
                chk($sformatf("v%0d ap_done", i), b0.ap_done, tbl[i].done);
                chk($sformatf("v%0d args_valid", i), b0.args_valid, tbl[i].av);
                chk($sformatf("v%0d ends_ready", i), b0.ends_ready, tbl[i].er);
                chk($sformatf("v%0d ret_out", i), b0.ret_out, tbl[i].ro);
            end
            if (i == 2)
                chk("args_data capture", b0.args_data, arg_exp);
            if (i == 13)
                chk("args_data after rst", b0.args_data, 128'h0);
            cyc();
        end

        // Held done: ap_done stays until ap_continue, start ignored.
        b1.ap_start = 1;
        cyc();
        b1.ap_start = 0; b1.ends_valid = 4'hF;
        cyc();
        b1.ends_valid = 0;
        for (int k = 0; k < 10; k++) begin
            b1.ap_start = 1;
            #1;
            chk($sformatf("hold done k%0d", k), b1.ap_done, 1'b1);
            chk($sformatf("hold ready k%0d", k), b1.ap_ready, 1'b0);
            cyc();
        end
        b1.ap_start = 0; b1.ap_continue = 1;
        cyc();
        b1.ap_continue = 0;
        chk("hold release ready", b1.ap_ready, 1'b1);
        chk("hold release done", b1.ap_done, 1'b0);

        // ap_continue already high on DONE entry: one DONE cycle.
        b1.ap_start = 1;
        cyc();
        b1.ap_start = 0; b1.ends_valid = 4'hF; b1.ap_continue = 1;
        cyc();
        b1.ends_valid = 0;
        chk("cont-high done", b1.ap_done, 1'b1);
        cyc();
        b1.ap_continue = 0;
        chk("cont-high ready", b1.ap_ready, 1'b1);
        chk("cont-high done off", b1.ap_done, 1'b0);

        // Cycle counter: last end handshake 7 cycles after RUN entry.
        b0.ap_start = 1; b0.args_ready = 4'hF; b0.ends_valid = 0;
        cyc();
        b0.ap_start = 0;
        for (int k = 0; k < 8; k++) begin
            b0.ends_valid = (k == 7) ? 4'hF : 4'h0;
            cyc();
        end
        b0.ends_valid = 0;
        chk("cc done", b0.ap_done, 1'b1);
        chk("cc at done", b0.cycle_count, exp_cc8);
        cyc();
        chk("cc idle ready", b0.ap_ready, 1'b1);
        chk("cc held", b0.cycle_count, exp_cc8);
        b0.ap_start = 1;
        cyc();
        b0.ap_start = 0;
        chk("cc cleared", b0.cycle_count, 32'd0);
        b0.ends_valid = 4'hF;
        cyc();
        b0.ends_valid = 0;
        chk("cc final done", b0.ap_done, 1'b1);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
